// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: op-bus layout,
// controller states, decoded op kinds and small operand helpers.
package mdu_ctrl_pkg;

    localparam int MDU_OP_WD = 6;

    // Bit positions inside the one-hot {mult, multu, div, divu, mthi, mtlo} bus.
    localparam int OP_MULT_BIT  = 5;
    localparam int OP_MULTU_BIT = 4;
    localparam int OP_DIV_BIT   = 3;
    localparam int OP_DIVU_BIT  = 2;
    localparam int OP_MTHI_BIT  = 1;
    localparam int OP_MTLO_BIT  = 0;

    localparam int DIV_ITERS = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } mdu_state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MTHI,
        OP_MTLO
    } mdu_op_t;

    // Several set bits resolve as mult > multu > div > divu > mthi > mtlo.
    function automatic mdu_op_t decode_op(input logic [MDU_OP_WD-1:0] op);
        if (op[OP_MULT_BIT])  return OP_MULT;
        if (op[OP_MULTU_BIT]) return OP_MULTU;
        if (op[OP_DIV_BIT])   return OP_DIV;
        if (op[OP_DIVU_BIT])  return OP_DIVU;
        if (op[OP_MTHI_BIT])  return OP_MTHI;
        if (op[OP_MTLO_BIT])  return OP_MTLO;
        return OP_NONE;
    endfunction

    // Two's-complement magnitude for signed operands, raw value otherwise.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_div.sv
// Unsigned 32-iteration restoring divider, one quotient bit per cycle, MSB first.
// done marks the cycle whose closing edge performs the final iteration.
module mdu_div
    import mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CNT_W = $clog2(DIV_ITERS);

    logic [CNT_W-1:0] count;
    logic [31:0]      quo_q;
    logic [31:0]      rem_q;
    logic [31:0]      dsr_q;
    logic [32:0]      rem_shift;
    logic [31:0]      rem_sub;
    logic             fits;

    // The partial remainder stays below the divisor, so the shifted value
    // needs one extra bit and the difference always fits back into 32.
    assign rem_shift = {rem_q, quo_q[31]};
    assign rem_sub   = rem_shift[31:0] - dsr_q;
    assign fits      = (rem_shift >= {1'b0, dsr_q});

    assign done      = busy && (count == CNT_W'(DIV_ITERS - 1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= '0;
        end else if (busy) begin
            count <= count + CNT_W'(1);
            if (done) busy <= 1'b0;
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded at
    // start before anything reads them, and busy alone gates their use.
    always_ff @(posedge clk) begin
        if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
        end else if (busy) begin
            quo_q <= {quo_q[30:0], fits};
            rem_q <= fits ? rem_sub : rem_shift[31:0];
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// EXE-stage multiply/divide controller: sequences MULT/DIV, executes MTHI/MTLO
// and owns HI/LO, which are written exactly once per instruction.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_STAGES = 2
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [MDU_OP_WD-1:0] req_op,
    input  logic [31:0]          req_src1,
    input  logic [31:0]          req_src2,
    input  logic                 req_ack,
    input  logic                 flush,
    output logic                 req_ready,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          hi,
    output logic [31:0]          lo
);

    localparam int CNT_W = 2;

    mdu_state_t       state;
    mdu_state_t       state_next;
    mdu_op_t          op;
    logic             accept;
    logic             is_mul;
    logic             is_sdiv;
    logic [CNT_W-1:0] mul_cnt;

    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_signed;
    logic [63:0]      mul_a_ext;
    logic [63:0]      mul_b_ext;
    logic [63:0]      product;

    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [31:0]      div_quo;
    logic [31:0]      div_rem;
    logic             div_neg_q;
    logic             div_neg_r;
    logic             div_zero;
    logic [31:0]      div_src1;
    logic [31:0]      quo_fixed;
    logic [31:0]      rem_fixed;

    logic             hi_we;
    logic             lo_we;
    logic [31:0]      hi_d;
    logic [31:0]      lo_d;

    assign op      = decode_op(req_op);
    assign accept  = (state == ST_IDLE) && req_valid && (op != OP_NONE) && !flush;
    assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    assign is_sdiv = (op == OP_DIV);

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state == ST_MUL) || (state == ST_FIX) || ((state == ST_DIV) && div_busy);

    // Extending to 64 bits first makes the low half of a plain multiply the
    // exact signed or unsigned 32x32 product.
    assign mul_a_ext = {{32{mul_signed & mul_a[31]}}, mul_a};
    assign mul_b_ext = {{32{mul_signed & mul_b[31]}}, mul_b};
    assign product   = mul_a_ext * mul_b_ext;

    assign quo_fixed = div_neg_q ? (32'd0 - div_quo) : div_quo;
    assign rem_fixed = div_neg_r ? (32'd0 - div_rem) : div_rem;

    mdu_div u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .abort     (flush),
        .dividend  (mag32(req_src1, is_sdiv)),
        .divisor   (mag32(req_src2, is_sdiv)),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset)                   mul_cnt <= '0;
        else if (accept && is_mul)   mul_cnt <= CNT_W'(MUL_STAGES - 1);
        else if (state == ST_MUL && mul_cnt != '0)
                                     mul_cnt <= mul_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mul_a      <= req_src1;
            mul_b      <= req_src2;
            mul_signed <= (op == OP_MULT);
            div_neg_q  <= is_sdiv && (req_src1[31] ^ req_src2[31]);
            div_neg_r  <= is_sdiv && req_src1[31];
            div_zero   <= (req_src2 == 32'd0);
            div_src1   <= req_src1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_d;
            if (lo_we) lo <= lo_d;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        div_start  = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        hi_d       = hi;
        lo_d       = lo;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: state_next = ST_MUL;
                        OP_DIV, OP_DIVU: begin
                            div_start  = 1'b1;
                            state_next = ST_DIV;
                        end
                        OP_MTHI: begin
                            done       = 1'b1;
                            hi_we      = 1'b1;
                            hi_d       = req_src1;
                            state_next = req_ack ? ST_IDLE : ST_DONE;
                        end
                        OP_MTLO: begin
                            done       = 1'b1;
                            lo_we      = 1'b1;
                            lo_d       = req_src1;
                            state_next = req_ack ? ST_IDLE : ST_DONE;
                        end
                        default: state_next = ST_IDLE;
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_cnt == '0) begin
                    done         = 1'b1;
                    hi_we        = 1'b1;
                    lo_we        = 1'b1;
                    {hi_d, lo_d} = product;
                    state_next   = req_ack ? ST_IDLE : ST_DONE;
                end
            end
            ST_DIV: begin
                if (div_done) state_next = ST_FIX;
            end
            ST_FIX: begin
                hi_we      = 1'b1;
                lo_we      = 1'b1;
                hi_d       = div_zero ? div_src1 : rem_fixed;
                lo_d       = div_zero ? 32'hFFFF_FFFF : quo_fixed;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (req_ack) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (flush) begin
            state_next = ST_IDLE;
            done       = 1'b0;
            div_start  = 1'b0;
            hi_we      = 1'b0;
            lo_we      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO are queued when an op is
// issued and popped when the controller signals done.
module tb_mdu_ctrl;

    localparam logic [5:0] OPB_MULT  = 6'b100000;
    localparam logic [5:0] OPB_MULTU = 6'b010000;
    localparam logic [5:0] OPB_DIV   = 6'b001000;
    localparam logic [5:0] OPB_DIVU  = 6'b000100;
    localparam logic [5:0] OPB_MTHI  = 6'b000010;
    localparam logic [5:0] OPB_MTLO  = 6'b000001;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [5:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        req_ack;
    logic        flush;
    logic        req_ready;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mdu_ctrl #(.MUL_STAGES(MUL_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .req_ack   (req_ack),
        .flush     (flush),
        .req_ready (req_ready),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Issue one MULT/DIV-class op, follow it to done, acknowledge and score it.
    task automatic run_op(input string name, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int lat, input bit is_div);
        exp_t e;
        int   cyc;
        bit   seen;
        int   busy_bad;
        e.hi = ehi; e.lo = elo; e.name = name;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; req_ack = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL %s_ready: got %b expected 1", name, req_ready);
        end
        cyc = 0; seen = 1'b0; busy_bad = 0;
        while (!seen && cyc <= 100) begin
            if (busy !== ((cyc > 0) && !(is_div && cyc == lat))) busy_bad++;
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
                req_src1 = $urandom; req_src2 = $urandom;
                #1;
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s_latency: no done within 100 cycles, expected %0d", name, lat);
        end else if (cyc != lat) begin
            errors++; $display("FAIL %s_latency: got %0d cycles expected %0d", name, cyc, lat);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++; $display("FAIL %s_busy: %0d cycles with wrong busy, expected 0", name, busy_bad);
        end
        req_ack = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_ack = 1'b0; req_op = '0;
        #1;
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL %s_scoreboard: queue empty, expected one entry", name);
        end else begin
            e = sb_q.pop_front();
            model_hi = e.hi; model_lo = e.lo;
            if (hi !== e.hi || lo !== e.lo) begin
                errors++;
                $display("FAIL %s_hilo: got hi=%h lo=%h expected hi=%h lo=%h", e.name, hi, lo, e.hi, e.lo);
            end
        end
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL %s_idle_after_ack: got ready=%b done=%b expected 1/0", name, req_ready, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
        req_ack = 1'b0; flush = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", hi, lo);
        end
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got ready=%b busy=%b done=%b expected 1/0/0", req_ready, busy, done);
        end
        reset = 1'b0;
    endtask

    task automatic test_mult();
        logic [31:0] a, b;
        logic [63:0] p;
        run_op("multu_max", OPB_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, 1'b0);
        run_op("mult_neg3x5", OPB_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT, 1'b0);
        run_op("mult_minxmin", OPB_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MUL_LAT, 1'b0);
        run_op("multu_carry", OPB_MULTU, 32'h8000_0000, 32'd2, 32'h0000_0001, 32'h0, MUL_LAT, 1'b0);
        run_op("mult_prio", OPB_MULT | OPB_MTLO, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            if (i[0]) begin
                p = longint'(int'(a)) * longint'(int'(b));
                run_op("mult_rand", OPB_MULT, a, b, p[63:32], p[31:0], MUL_LAT, 1'b0);
            end else begin
                p = 64'(a) * 64'(b);
                run_op("multu_rand", OPB_MULTU, a, b, p[63:32], p[31:0], MUL_LAT, 1'b0);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] a, b;
        int          q, r;
        run_op("div_neg7by2", OPB_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, 1'b1);
        run_op("div_7byneg2", OPB_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_LAT, 1'b1);
        run_op("divu_by0", OPB_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, DIV_LAT, 1'b1);
        run_op("div_neg_by0", OPB_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_LAT, 1'b1);
        run_op("div_overflow", OPB_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_LAT, 1'b1);
        run_op("divu_max", OPB_DIVU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h7FFF_FFFF, DIV_LAT, 1'b1);
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = 32'($urandom_range(1, 5000));
            if (i[0]) begin
                if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
                q = int'(a) / int'(b); r = int'(a) % int'(b);
                run_op("div_rand", OPB_DIV, a, b, 32'(r), 32'(q), DIV_LAT, 1'b1);
            end else begin
                run_op("divu_rand", OPB_DIVU, a, b, a % b, a / b, DIV_LAT, 1'b1);
            end
        end
    endtask

    task automatic test_mthi_ack();
        @(negedge clk);
        req_valid = 1'b1; req_op = OPB_MTHI; req_src1 = 32'h1234_5678; req_src2 = 32'hDEAD_0000; req_ack = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL mthi_done_same_cycle: got %b expected 1", done);
        end
        @(negedge clk);
        req_valid = 1'b0; req_ack = 1'b0; req_op = '0;
        #1;
        model_hi = 32'h1234_5678;
        checks++;
        if (hi !== model_hi || lo !== model_lo) begin
            errors++; $display("FAIL mthi_write: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, model_hi, model_lo);
        end
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL mthi_stays_idle: got ready=%b done=%b expected 1/0", req_ready, done);
        end
    endtask

    task automatic test_done_hold();
        @(negedge clk);
        req_valid = 1'b1; req_op = OPB_MTLO; req_src1 = 32'hCAFE_F00D; req_ack = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL mtlo_done_same_cycle: got %b expected 1", done);
        end
        model_lo = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_src1 = $urandom;
            #1;
            checks++;
            if (done !== 1'b1 || req_ready !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
                errors++;
                $display("FAIL done_hold_%0d: got done=%b ready=%b hi=%h lo=%h expected 1/0 hi=%h lo=%h",
                         i, done, req_ready, hi, lo, model_hi, model_lo);
            end
        end
        req_ack = 1'b1;
        @(negedge clk);
        req_op = OPB_MTHI; req_src1 = 32'h0BAD_BEEF; req_ack = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b1) begin
            errors++; $display("FAIL accept_after_release: got ready=%b done=%b expected 1/1", req_ready, done);
        end
        @(negedge clk);
        req_valid = 1'b0; req_ack = 1'b0; req_op = '0;
        #1;
        model_hi = 32'h0BAD_BEEF;
        checks++;
        if (hi !== model_hi || lo !== model_lo) begin
            errors++; $display("FAIL followup_mthi: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, model_hi, model_lo);
        end
    endtask

    task automatic test_ignore_zero_op();
        @(negedge clk);
        req_valid = 1'b1; req_op = '0; req_src1 = 32'h5555_AAAA; req_ack = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL zero_op_done: got %b expected 0", done);
        end
        @(negedge clk);
        req_valid = 1'b0; req_ack = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
            errors++;
            $display("FAIL zero_op_ignored: got ready=%b busy=%b hi=%h lo=%h expected 1/0 hi=%h lo=%h",
                     req_ready, busy, hi, lo, model_hi, model_lo);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        req_valid = 1'b1; req_op = OPB_DIV; req_src1 = 32'd100; req_src2 = 32'd7; req_ack = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL flush_div_busy: got %b expected 1", busy);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0; req_op = '0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
            errors++;
            $display("FAIL flush_div: got ready=%b busy=%b done=%b hi=%h lo=%h expected 1/0/0 hi=%h lo=%h",
                     req_ready, busy, done, hi, lo, model_hi, model_lo);
        end
        @(negedge clk);
        req_valid = 1'b1; req_op = OPB_MTHI; req_src1 = 32'hFFFF_0000; req_ack = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL flush_mthi_done: got %b expected 0", done);
        end
        @(negedge clk);
        req_valid = 1'b0; req_ack = 1'b0; req_op = '0; flush = 1'b0;
        #1;
        checks++;
        if (hi !== model_hi || req_ready !== 1'b1) begin
            errors++; $display("FAIL flush_mthi: got hi=%h ready=%b expected hi=%h ready=1", hi, req_ready, model_hi);
        end
        run_op("div_after_flush", OPB_DIV, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_op = OPB_MULT; req_src1 = 32'h1234; req_src2 = 32'h5678; req_ack = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_mid_busy: got %b expected 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0; req_op = '0;
        #1;
        model_hi = '0; model_lo = '0;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || req_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mul: got hi=%h lo=%h ready=%b done=%b busy=%b expected 0/0/1/0/0",
                     hi, lo, req_ready, done, busy);
        end
        run_op("mult_after_reset", OPB_MULT, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, MUL_LAT, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_ack();
        test_done_hold();
        test_ignore_zero_op();
        test_flush();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
